// File: rtl/adsr_env.sv
// adsr_env: ADSR envelope generator that scales a DDS sample stream by the envelope level.
module adsr_env #(
  parameter int DATA_WDTH    = 24,
  parameter int ENV_WDTH     = 16,
  parameter int ATTACK_STEP  = 16384,
  parameter int DECAY_STEP   = 8192,
  parameter int SUSTAIN_LVL  = 32768,
  parameter int RELEASE_STEP = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 note_on,
  input  logic                 note_off,
  input  logic [DATA_WDTH-1:0] in_sample,
  input  logic                 in_strobe,
  output logic [DATA_WDTH-1:0] out_sample,
  output logic                 out_valid,
  output logic [ENV_WDTH-1:0]  env_level,
  output logic [2:0]           env_state
);
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
  localparam int PW = DATA_WDTH + ENV_WDTH + 1;
  localparam logic [ENV_WDTH:0] MAX = {1'b0, {ENV_WDTH{1'b1}}};
  localparam logic [ENV_WDTH:0] ATK = ATTACK_STEP[ENV_WDTH:0];
  localparam logic [ENV_WDTH:0] DEC = DECAY_STEP[ENV_WDTH:0];
  localparam logic [ENV_WDTH:0] SUS = SUSTAIN_LVL[ENV_WDTH:0];
  localparam logic [ENV_WDTH:0] REL = RELEASE_STEP[ENV_WDTH:0];
  state_t state_q, state_d;
  logic [ENV_WDTH-1:0] level_q, level_d, s1_level_q, s1_level_d;
  logic [ENV_WDTH:0] lvl, sum;
  logic signed [DATA_WDTH-1:0] s1_sample_q, s1_sample_d;
  logic [DATA_WDTH-1:0] out_sample_q, out_sample_d;
  logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic signed [PW-1:0] prod;
  always_comb begin
    lvl = {1'b0, level_q};
    sum = lvl + ATK;
    state_d = state_q;
    level_d = level_q;
    if (note_on) state_d = ATTACK;
    else if (note_off && state_q inside {ATTACK, DECAY, SUSTAIN}) state_d = RELEASE;
    else if (in_strobe)
      case (state_q)
        IDLE: level_d = '0;
        ATTACK: begin
          level_d = sum >= MAX ? MAX[ENV_WDTH-1:0] : sum[ENV_WDTH-1:0];
          state_d = sum >= MAX ? DECAY : ATTACK;
        end
        DECAY: begin
          level_d = lvl <= SUS + DEC ? SUS[ENV_WDTH-1:0] : level_q - DEC[ENV_WDTH-1:0];
          state_d = lvl <= SUS + DEC ? SUSTAIN : DECAY;
        end
        RELEASE: begin
          level_d = lvl <= REL ? '0 : level_q - REL[ENV_WDTH-1:0];
          state_d = lvl <= REL ? IDLE : RELEASE;
        end
        default: level_d = level_q;
      endcase
  end
  always_comb begin
    s1_valid_d = in_strobe;
    s1_sample_d = in_strobe ? in_sample : s1_sample_q;
    s1_level_d = in_strobe ? level_q : s1_level_q;
    prod = s1_sample_q * $signed({1'b0, s1_level_q});
    out_valid_d = s1_valid_q;
    out_sample_d = s1_valid_q ? DATA_WDTH'(prod >>> ENV_WDTH) : out_sample_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      s1_valid_q <= 1'b0;
      s1_sample_q <= '0;
      s1_level_q <= '0;
      out_valid_q <= 1'b0;
      out_sample_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      s1_valid_q <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
      s1_level_q <= s1_level_d;
      out_valid_q <= out_valid_d;
      out_sample_q <= out_sample_d;
    end
  end
  assign out_sample = out_sample_q;
  assign out_valid = out_valid_q;
  assign env_level = level_q;
  assign env_state = state_q;
endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: random and directed stimulus checked against a behavioural envelope model.
module tb_adsr_env;
  localparam int A = 16384, D = 8192, S = 32768, R = 4096, MAX = 65535;
  logic clk = 1'b0, rst = 1'b1, note_on = 1'b0, note_off = 1'b0, in_strobe = 1'b0;
  logic [23:0] in_sample = '0, out_sample;
  logic out_valid;
  logic [15:0] env_level;
  logic [2:0] env_state;
  typedef struct {int due; logic [23:0] val;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, st = 0, lvl = 0;
  logic [23:0] exp_sample = '0;
  adsr_env dut (
    .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off),
    .in_sample(in_sample), .in_strobe(in_strobe), .out_sample(out_sample),
    .out_valid(out_valid), .env_level(env_level), .env_state(env_state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick(input bit on, input bit off, input bit stb, input bit r, input logic [23:0] smp);
    longint s, p;
    bit v;
    note_on = on;
    note_off = off;
    in_strobe = stb;
    rst = r;
    in_sample = smp;
    if (r) begin
      st = 0;
      lvl = 0;
      q.delete();
      exp_sample = '0;
    end else begin
      if (stb) begin
        s = $signed(smp);
        p = s * lvl;
        q.push_back('{cyc + 2, 24'(p >>> 16)});
      end
      if (on) st = 1;
      else if (off && st >= 1 && st <= 3) st = 4;
      else if (stb)
        case (st)
          0: lvl = 0;
          1: begin lvl = lvl + A > MAX ? MAX : lvl + A; if (lvl == MAX) st = 2; end
          2: begin lvl = lvl - D < S ? S : lvl - D; if (lvl == S) st = 3; end
          4: begin lvl = lvl - R < 0 ? 0 : lvl - R; if (lvl == 0) st = 0; end
          default: ;
        endcase
    end
    @(negedge clk);
    cyc++;
    v = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      v = 1'b1;
      exp_sample = q[0].val;
      void'(q.pop_front());
    end
    chk("out_valid", out_valid, v);
    chk("out_sample", out_sample, exp_sample);
    chk("env_level", env_level, lvl);
    chk("env_state", env_state, st);
  endtask
  task automatic strobes(input int n);
    repeat (n) tick(0, 0, 1, 0, 24'($urandom));
  endtask
  int att_lvl[8] = '{16384, 32768, 49152, 65535, 57343, 49151, 40959, 32768};
  int att_st[8] = '{1, 1, 1, 2, 2, 2, 2, 3};
  initial begin
    @(negedge clk);
    tick(0, 0, 0, 1, '0);
    tick(1, 1, 1, 1, 24'h123456);
    chk("rst_level", env_level, 0);
    chk("rst_state", env_state, 0);
    chk("rst_valid", out_valid, 0);
    tick(0, 0, 0, 0, '0);
    chk("rst_no_valid", out_valid, 0);
    tick(0, 0, 1, 0, 24'h400000);
    chk("idle_valid_early", out_valid, 0);
    tick(0, 0, 0, 0, '0);
    chk("idle_valid", out_valid, 1);
    chk("idle_sample", out_sample, 0);
    chk("idle_state", env_state, 0);
    tick(1, 0, 0, 0, '0);
    for (int i = 0; i < 8; i++) begin
      strobes(1);
      chk("att_dec_level", env_level, att_lvl[i]);
      chk("att_dec_state", env_state, att_st[i]);
    end
    tick(0, 0, 1, 0, 24'h400000);
    tick(0, 0, 0, 0, '0);
    chk("sus_pos", out_sample, 24'h200000);
    tick(0, 0, 1, 0, 24'hC00000);
    tick(0, 0, 0, 0, '0);
    chk("sus_neg", out_sample, 24'hE00000);
    tick(0, 1, 0, 0, '0);
    for (int i = 1; i <= 8; i++) begin
      strobes(1);
      chk("rel_level", env_level, 32768 - 4096 * i);
      chk("rel_state", env_state, i == 8 ? 0 : 4);
    end
    tick(0, 1, 0, 0, '0);
    chk("idle_off_ignored", env_state, 0);
    tick(1, 0, 0, 0, '0);
    strobes(8);
    tick(0, 1, 0, 0, '0);
    strobes(3);
    chk("pre_collide", env_level, 20480);
    tick(1, 1, 1, 0, 24'h7FFFFF);
    chk("collide_state", env_state, 1);
    chk("collide_level", env_level, 20480);
    strobes(1);
    chk("collide_step", env_level, 36864);
    tick(0, 0, 1, 0, 24'h400000);
    tick(0, 0, 0, 1, '0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_level", env_level, 0);
    chk("rst_mid_state", env_state, 0);
    tick(0, 0, 0, 0, '0);
    chk("rst_mid_valid2", out_valid, 0);
    for (int i = 0; i < 4000; i++)
      tick($urandom_range(99) < 3, $urandom_range(99) < 3, $urandom_range(1) == 1,
           $urandom_range(999) < 4, 24'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
